// File: rtl/demux4_reg_pkg.sv
// demux4_reg_pkg: shared slot indices and default widths for the 1:4 write demux
package demux4_reg_pkg;
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/demux4_reg_if.sv
// demux4_reg_if: producer offer, per-slot outputs and consumer acks of the write demux
interface demux4_reg_if #(
  parameter int WIDTH = demux4_reg_pkg::DEF_WIDTH,
  parameter int CNT_W = demux4_reg_pkg::DEF_CNT_W
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ack;
  logic [CNT_W-1:0] accept_cnt;
  modport master (
    output in_data, in_sel, in_valid, out_ack,
    input  in_ready, out_a, out_b, out_c, out_d, out_valid, accept_cnt
  );
  modport slave (
    input  in_data, in_sel, in_valid, out_ack,
    output in_ready, out_a, out_b, out_c, out_d, out_valid, accept_cnt
  );
endinterface

// File: rtl/demux4_reg_slot.sv
// demux4_slot: one holding register with a full flag, refilled or drained by its consumer
module demux4_slot #(
  parameter int WIDTH = demux4_reg_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             can_accept
);
  assign can_accept = !valid | ack;
  // a write sets full and replaces data; an ack alone only clears full
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (wr_en) data <= wr_data;
      valid <= wr_en | (valid & ~ack);
    end
  end
endmodule

// File: rtl/demux4_reg.sv
// demux4_reg: routes one word per cycle into one of four held slots with valid/ready flow control
module demux4_reg #(
  parameter int WIDTH = demux4_reg_pkg::DEF_WIDTH,
  parameter int CNT_W = demux4_reg_pkg::DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  demux4_reg_if.slave bus
);
  import demux4_reg_pkg::*;
  logic [3:0]       wr_en;
  logic [3:0]       can_accept;
  logic [WIDTH-1:0] data [4];
  assign bus.in_ready = can_accept[bus.in_sel];
  assign wr_en = {4{bus.in_valid & bus.in_ready}} & (4'd1 << bus.in_sel);
  for (genvar i = 0; i < 4; i++) begin : g_slot
    demux4_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[i]),
      .wr_data    (bus.in_data),
      .ack        (bus.out_ack[i]),
      .data       (data[i]),
      .valid      (bus.out_valid[i]),
      .can_accept (can_accept[i])
    );
  end
  assign bus.out_a = data[SLOT_A];
  assign bus.out_b = data[SLOT_B];
  assign bus.out_c = data[SLOT_C];
  assign bus.out_d = data[SLOT_D];
  // count every accepted word, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) bus.accept_cnt <= '0;
    else if (|wr_en) bus.accept_cnt <= bus.accept_cnt + 1'b1;
  end
endmodule

// File: tb/tb_demux4_reg.sv
// tb_demux4_reg: directed and random checks of demux4_reg against a slot-array model
module tb_demux4_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] md [4];
  logic [3:0]  mv;
  logic [7:0]  mc;
  demux4_reg_if #(.WIDTH(32), .CNT_W(8)) bus ();
  demux4_reg #(.WIDTH(32), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("out_a", 64'(bus.out_a), 64'(md[0]));
    chk("out_b", 64'(bus.out_b), 64'(md[1]));
    chk("out_c", 64'(bus.out_c), 64'(md[2]));
    chk("out_d", 64'(bus.out_d), 64'(md[3]));
    chk("out_valid", 64'(bus.out_valid), 64'(mv));
    chk("accept_cnt", 64'(bus.accept_cnt), 64'(mc));
  endtask

  task automatic step(input logic [31:0] d, input logic [1:0] s, input logic v, input logic [3:0] a);
    logic rdy;
    bus.in_data = d;
    bus.in_sel = s;
    bus.in_valid = v;
    bus.out_ack = a;
    rdy = !mv[s] || a[s];
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (v && rdy && s == 2'(i)) begin
        md[i] = d;
        mv[i] = 1'b1;
      end else if (a[i]) mv[i] = 1'b0;
    end
    if (v && rdy) mc = mc + 8'd1;
    #1;
    chk_all();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    bus.in_data = $urandom;
    bus.in_sel = 2'($urandom);
    bus.in_valid = 1'b1;
    bus.out_ack = 4'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) md[i] = '0;
    mv = '0;
    mc = '0;
    chk_all();
  endtask

  initial begin
    bus.in_data = '0;
    bus.in_sel = '0;
    bus.in_valid = 1'b0;
    bus.out_ack = '0;
    @(posedge clk);
    #1;
    do_rst();
    for (int s = 0; s < 4; s++) step('0, 2'(s), 1'b0, 4'b0000);
    step(32'h0000_00AA, 2'b01, 1'b1, 4'b0000);
    step(32'h0000_0077, 2'b10, 1'b1, 4'b0000);
    for (int k = 0; k < 3; k++) step(32'h1234_5678, 2'b10, 1'b1, 4'b0000);
    step(32'hDEAD_BEEF, 2'b00, 1'b1, 4'b0000);
    step(32'h0000_0001, 2'b11, 1'b1, 4'b0000);
    step(32'h0000_0002, 2'b11, 1'b1, 4'b1000);
    step('0, 2'b00, 1'b0, 4'b0001);
    step('0, 2'b00, 1'b0, 4'b0001);
    step(32'h0000_0055, 2'b00, 1'b1, 4'b0000);
    step('0, 2'b00, 1'b0, 4'b0001);
    do_rst();
    for (int k = 0; k < 256; k++) step($urandom, 2'(k), 1'b1, 4'b1111);
    for (int k = 0; k < 400; k++) step($urandom, 2'($urandom), 1'($urandom), 4'($urandom));
    do_rst();
    for (int k = 0; k < 100; k++) step($urandom, 2'($urandom), 1'($urandom), 4'($urandom));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux4_reg.md
Name: demux4_reg

Overview:
- Write-side counterpart of the team's 4-input, 32-bit result selector: distributes one incoming WIDTH-bit word to one of four slot registers (A–D) chosen by a 2-bit select.
- Each slot holds its word with a valid flag until the downstream consumer acknowledges it.
- Sits between the ALU/write-back stage and the four operand/result holding registers feeding the 4:1 selector.
- Provides valid/ready flow control so no unconsumed word is ever overwritten.

Parameters:
- WIDTH, 32, data width of input and each slot.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to distribute
- in_sel  input  2  target slot: 00=A, 01=B, 10=C, 11=D
- in_valid  input  1  producer offers in_data/in_sel this cycle
- in_ready  output  1  block can accept the offer this cycle
- out_a  output  WIDTH  slot A register
- out_b  output  WIDTH  slot B register
- out_c  output  WIDTH  slot C register
- out_d  output  WIDTH  slot D register
- out_valid  output  4  per-slot full flag, bit0=A … bit3=D
- out_ack  input  4  per-slot consume strobe from consumer
- accept_cnt  output  CNT_W  number of accepted words, modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_a..out_d = 0, out_valid = 4'b0000, accept_cnt = 0.
  - Any in-flight offer or ack in that cycle is ignored.
  - Reset dominates all other events.
- in_ready is combinational: !out_valid[in_sel] | out_ack[in_sel]. It depends only on the selected slot, so a full slot A does not block writes to B–D.
- Accept occurs when in_valid & in_ready at a rising edge. Next cycle:
  - the selected slot register = in_data;
  - out_valid[in_sel] = 1;
  - accept_cnt += 1, wrapping from 2^CNT_W-1 to 0.
- Latency: a word is visible on its out_x with valid set one cycle after acceptance. There is no bypass.
- Ack with out_valid[i]=1 and no same-cycle accept into slot i: out_valid[i] clears next cycle. Slot data holds its last value (not cleared).
- Ack with out_valid[i]=0: ignored, no state change.
- Simultaneous ack and accept into the same slot: data replaced by in_data, out_valid[i] stays 1. This is a back-to-back refill with no bubble.
- Acks on multiple slots in the same cycle: each is handled independently.
- in_valid=1 with in_ready=0:
  - no state change; the producer must hold in_data/in_sel stable until accepted;
  - accept_cnt unchanged.
- in_valid=0: in_sel and in_data are don't-care. Nothing is written.
- Exactly one slot can be written per cycle. Slot registers never change except on accept or reset.

Decomposition:
- Shared package holds:
  - slot index constants SLOT_A=2'd0, SLOT_B=2'd1, SLOT_C=2'd2, SLOT_D=2'd3;
  - WIDTH default 32.
- One sub-module, demux4_slot, instanced four times. It contains:
  - a WIDTH-bit data register plus valid flip-flop;
  - inputs clk, rst, wr_en, wr_data, ack;
  - outputs data, valid, can_accept.
- The top level contains:
  - select decode to per-slot wr_en;
  - the in_ready mux over can_accept;
  - accept_cnt.

Test Plan:
- Reset then idle → out_a..out_d=0, out_valid=0000, accept_cnt=0, in_ready=1 for every in_sel.
- Write 0x0000_00AA to sel=01 → next cycle out_b=0x0000_00AA, out_valid=0010, accept_cnt=1; out_a/out_c/out_d remain 0.
- Slot C full:
  - offer 0x1234_5678 to sel=10 with no ack → in_ready=0 and out_c keeps its prior value for 3 cycles;
  - offer 0xDEAD_BEEF to sel=00 → accepted immediately.
- Slot D full with 0x1, then same cycle out_ack[3]=1 and write 0x2 to sel=11 → out_d=0x2, out_valid[3] stays 1, accept_cnt increments once.
- Ack slot A while empty → no change; ack slot A after writing 0x55 → out_valid[0]=0 next cycle and out_a still 0x55.
- 256 consecutive accepts rotating sel=00..11 with ack asserted every cycle → accept_cnt wraps to 0.
- Assert rst mid-stream → all outputs 0 the following cycle.
